// File: rtl/aig_bench_bist.sv
// BIST harness for a combinational benchmark core: a Galois LFSR sources patterns,
// a MISR compacts the responses, and the final signature is compared with a golden value.
module aig_bench_bist #(
    parameter int               IN_W      = 14,
    parameter int               OUT_W     = 22,
    parameter logic [IN_W-1:0]  LFSR_POLY = 14'h002B,
    parameter logic [OUT_W-1:0] MISR_POLY = 22'h200001,
    parameter int               CNT_W     = 16,
    parameter int               LAT       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [OUT_W-1:0] golden_sig,
    output logic [IN_W-1:0]  pat_o,
    output logic             pat_valid_o,
    input  logic [OUT_W-1:0] resp_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [IN_W-1:0]  r_lfsr;
    logic [OUT_W-1:0] r_misr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic             r_pass;
    logic             r_shown;
    logic             w_run;
    logic             w_last;
    logic             w_dvld;
    logic             w_pipe_empty;

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] s);
        return {s[IN_W-2:0], 1'b0} ^ (s[IN_W-1] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] m,
                                                   input logic [OUT_W-1:0] r);
        return ({m[OUT_W-2:0], 1'b0} ^ (m[OUT_W-1] ? MISR_POLY : '0)) ^ r;
    endfunction

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_cnt == r_num - CNT_W'(1));

    // Valid delay line: marks the cycles in which resp_i belongs to a live pattern.
    generate
        if (LAT > 0) begin : g_vpipe
            logic [LAT-1:0] r_vpipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else if (abort) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe[0] <= w_run;
                    for (int i = 1; i < LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
                end
            end
            assign w_dvld       = r_vpipe[LAT-1];
            assign w_pipe_empty = ~|r_vpipe;
        end else begin : g_novpipe
            assign w_dvld       = w_run;
            assign w_pipe_empty = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lfsr  <= IN_W'(1);
            r_misr  <= '0;
            r_cnt   <= '0;
            r_num   <= '0;
            r_pass  <= 1'b0;
            r_shown <= 1'b0;
        end else begin
            if (w_dvld && !abort) r_misr <= misr_step(r_misr, resp_i);
            if (abort) begin
                r_state <= S_IDLE;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_lfsr  <= (seed != '0) ? seed : IN_W'(1);
                            r_misr  <= '0;
                            r_cnt   <= '0;
                            r_num   <= num_patterns;
                            r_pass  <= 1'b0;
                            r_shown <= 1'b1;
                            r_state <= (num_patterns != '0) ? S_RUN : S_DRAIN;
                        end
                    end
                    S_RUN: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // The step after the last pattern is skipped so pat_o keeps it through DRAIN.
                        if (w_last) r_state <= S_DRAIN;
                        else        r_lfsr  <= lfsr_step(r_lfsr);
                    end
                    S_DRAIN: begin
                        if (w_pipe_empty) r_state <= S_DONE;
                    end
                    default: begin
                        r_pass  <= (r_misr == golden_sig);
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign pat_o       = r_shown ? r_lfsr : '0;
    assign pat_valid_o = w_run;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign pass        = r_pass;
    assign signature   = r_misr;

endmodule

// File: tb/tb_aig_bench_bist.sv
// Self-checking bench for aig_bench_bist: a LAT=1 instance and a LAT=3 instance
// driven by registered model cores, checked against an arithmetic reference model.
module tb_aig_bench_bist;
    localparam int IN_W  = 14;
    localparam int OUT_W = 22;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [IN_W-1:0]  seed = '0;
    logic [CNT_W-1:0] num_patterns = '0;
    logic [OUT_W-1:0] golden_sig = '0;

    logic [IN_W-1:0]  pat1, pat3;
    logic             pv1, pv3, busy1, busy3, done1, done3, pass1, pass3;
    logic [OUT_W-1:0] sig1, sig3, resp1, resp3;
    logic [OUT_W-1:0] core1, c3a, c3b, c3c;
    logic             use_core = 1'b0;
    logic [OUT_W-1:0] resp_const = '0;
    logic             sel = 1'b0;

    logic [IN_W-1:0]  o_pat;
    logic             o_pv, o_busy, o_done, o_pass;
    logic [OUT_W-1:0] o_sig;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aig_bench_bist #(.LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .num_patterns(num_patterns), .golden_sig(golden_sig), .pat_o(pat1),
        .pat_valid_o(pv1), .resp_i(resp1), .busy(busy1), .done(done1),
        .pass(pass1), .signature(sig1)
    );

    aig_bench_bist #(.LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .num_patterns(num_patterns), .golden_sig(golden_sig), .pat_o(pat3),
        .pat_valid_o(pv3), .resp_i(resp3), .busy(busy3), .done(done3),
        .pass(pass3), .signature(sig3)
    );

    // Stand-in benchmark core: arbitrary mixing function, registered LAT times.
    function automatic int unsigned core_f(input int unsigned p);
        return ((p * 37) ^ (p << 8) ^ 32'h0002A5A5) & 32'h003FFFFF;
    endfunction

    always @(posedge clk) begin
        core1 <= OUT_W'(core_f(32'(pat1)));
        c3a   <= OUT_W'(core_f(32'(pat3)));
        c3b   <= c3a;
        c3c   <= c3b;
    end
    assign resp1 = use_core ? core1 : resp_const;
    assign resp3 = c3c;

    assign o_pat  = sel ? pat3  : pat1;
    assign o_pv   = sel ? pv3   : pv1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_pass = sel ? pass3 : pass1;
    assign o_sig  = sel ? sig3  : sig1;

    // Reference model: polynomial arithmetic on plain integers.
    function automatic int unsigned m_lfsr(input int unsigned s);
        int unsigned t;
        t = s << 1;
        if (t >= (32'd1 << IN_W)) t = (t - (32'd1 << IN_W)) ^ 32'h0000002B;
        return t;
    endfunction

    function automatic int unsigned m_misr(input int unsigned m, input int unsigned r);
        int unsigned t;
        t = m << 1;
        if (t >= (32'd1 << OUT_W)) t = (t - (32'd1 << OUT_W)) ^ 32'h00200001;
        return t ^ r;
    endfunction

    int unsigned exp_pats[$];
    int unsigned exp_sig;

    task automatic model(input int unsigned sd, input int n, input bit core, input int unsigned rc);
        int unsigned s, m;
        exp_pats.delete();
        s = (sd == 0) ? 1 : sd;
        m = 0;
        for (int i = 0; i < n; i++) begin
            exp_pats.push_back(s);
            m = m_misr(m, core ? core_f(s) : rc);
            s = m_lfsr(s);
        end
        exp_sig = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int got_pats[$];
    int done_cnt, done_at, drain_pat;

    function automatic int got_at(input int k);
        if (k < 0 || k >= got_pats.size()) return -1;
        return got_pats[k];
    endfunction

    function automatic int seq_bad();
        int b = 0;
        foreach (exp_pats[k]) if (got_at(k) != int'(exp_pats[k])) b++;
        return b;
    endfunction

    task automatic run_bist(input logic [IN_W-1:0] sd, input logic [CNT_W-1:0] n,
                            input logic [OUT_W-1:0] gold, input int glitch_at, input int budget);
        got_pats.delete();
        done_cnt  = 0;
        done_at   = -1;
        drain_pat = -1;
        seed = sd; num_patterns = n; golden_sig = gold; start = 1'b1;
        for (int t = 1; t <= budget; t++) begin
            tick();
            start = (t == glitch_at);
            if (o_pv) got_pats.push_back(int'(o_pat));
            if (o_busy && !o_pv && drain_pat < 0) drain_pat = int'(o_pat);
            if (o_done) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (done_at >= 0 && t >= done_at + 1) break;
        end
        start = 1'b0;
        if (done_at < 0) $display("FAIL run_timeout: got no done within %0d cycles, expected done", budget);
        if (done_at < 0) n_fail++;
    endtask

    typedef struct {
        logic [IN_W-1:0]  sd;
        logic [CNT_W-1:0] n;
        logic [OUT_W-1:0] rc;
        logic [OUT_W-1:0] gold;
        logic [OUT_W-1:0] sig;
        logic             ps;
        int               first;
        int               lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{14'h0001, 16'd15, 22'h0, 22'h0, 22'h000000, 1'b1, 1, 18};
        tbl[1] = '{14'h0001, 16'd1,  22'h1, 22'h1, 22'h000001, 1'b1, 1, 4};
        tbl[2] = '{14'h0005, 16'd2,  22'h1, 22'h2, 22'h000003, 1'b0, 5, 5};
        tbl[3] = '{14'h0000, 16'd3,  22'h0, 22'h0, 22'h000000, 1'b1, 1, 6};
        tbl[4] = '{14'h1234, 16'd0,  22'h1, 22'h0, 22'h000000, 1'b1, -1, 2};

        #12;
        check("rst_pat", 32'(pat1), 0);
        check("rst_valid", 32'(pv1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_pass", 32'(pass1), 0);
        check("rst_sig", 32'(sig1), 0);
        check("rst_sig3", 32'(sig3), 0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            use_core   = 1'b0;
            resp_const = tbl[i].rc;
            model(tbl[i].sd, int'(tbl[i].n), 1'b0, tbl[i].rc);
            run_bist(tbl[i].sd, tbl[i].n, tbl[i].gold, 0, 60);
            check($sformatf("v%0d_sig", i), 32'(o_sig), 32'(tbl[i].sig));
            check($sformatf("v%0d_pass", i), 32'(o_pass), 32'(tbl[i].ps));
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("v%0d_done_lat", i), done_at, tbl[i].lat);
            check($sformatf("v%0d_pat_count", i), got_pats.size(), 32'(tbl[i].n));
            check($sformatf("v%0d_first_pat", i), got_at(0), tbl[i].first);
            check($sformatf("v%0d_pat_seq_bad", i), seq_bad(), 0);
            if (tbl[i].n != 0)
                check($sformatf("v%0d_drain_pat", i), drain_pat, int'(exp_pats[exp_pats.size()-1]));
            if (i == 0) begin
                check("v0_pat13", got_at(13), 32'h2000);
                check("v0_pat14", got_at(14), 32'h002B);
            end
        end

        // Abort in the third RUN cycle, then restart one cycle later.
        resp_const = 22'h1;
        seed = 14'h1; num_patterns = 16'd10; golden_sig = '0; start = 1'b1;
        tick(); start = 1'b0;
        check("abort_pre_busy", 32'(busy1), 1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy1), 0);
        check("abort_valid", 32'(pv1), 0);
        check("abort_done", 32'(done1), 0);
        check("abort_pass", 32'(pass1), 0);
        run_bist(14'h1, 16'd2, 22'h3, 0, 40);
        check("restart_sig", 32'(sig1), 3);
        check("restart_pass", 32'(pass1), 1);
        check("restart_lat", done_at, 5);

        // Aborted run never reports done.
        seed = 14'h1; num_patterns = 16'd10; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        done_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (done1) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_pass_cleared", 32'(pass1), 0);

        // start together with abort stays in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy1), 0);
        check("start_abort_valid", 32'(pv1), 0);

        // start pulse during RUN is ignored.
        resp_const = 22'h1;
        model(7, 8, 1'b0, 1);
        run_bist(14'h7, 16'd8, 22'h0, 3, 40);
        check("glitch_done_cnt", done_cnt, 1);
        check("glitch_lat", done_at, 11);
        check("glitch_pat_count", got_pats.size(), 8);
        check("glitch_pat_seq_bad", seq_bad(), 0);
        check("glitch_sig", 32'(sig1), exp_sig);
        check("glitch_idle_after", 32'(busy1), 0);

        // Asynchronous reset in DRAIN.
        seed = 14'h1; num_patterns = 16'd4; start = 1'b1;
        done_at = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            start = 1'b0;
            if (busy1 && !pv1) begin
                done_at = t;
                break;
            end
        end
        check("drain_reached", done_at, 5);
        check("pre_reset_sig", 32'(sig1), 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy1), 0);
        check("async_rst_valid", 32'(pv1), 0);
        check("async_rst_done", 32'(done1), 0);
        check("async_rst_pass", 32'(pass1), 0);
        check("async_rst_sig", 32'(sig1), 0);
        check("async_rst_pat", 32'(pat1), 0);
        #3 rst_n = 1'b1;
        tick();

        // Randomized runs through the LAT=1 model core.
        use_core = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int unsigned sd;
            int n;
            sd = $urandom_range(0, 16383);
            n  = $urandom_range(1, 40);
            model(sd, n, 1'b1, 0);
            run_bist(IN_W'(sd), CNT_W'(n), OUT_W'(exp_sig), 0, n + 20);
            check($sformatf("rnd%0d_sig", r), 32'(sig1), exp_sig);
            check($sformatf("rnd%0d_pass", r), 32'(pass1), 1);
            check($sformatf("rnd%0d_pat_seq_bad", r), seq_bad(), 0);
            check($sformatf("rnd%0d_lat", r), done_at, n + 3);
        end

        // LAT=3 instance over 1000 patterns.
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        tick();
        sel = 1'b1;
        begin
            int unsigned sd;
            sd = $urandom_range(1, 16383);
            model(sd, 1000, 1'b1, 0);
            run_bist(IN_W'(sd), 16'd1000, OUT_W'(exp_sig), 0, 1100);
            check("lat3_sig", 32'(sig3), exp_sig);
            check("lat3_pass", 32'(pass3), 1);
            check("lat3_pat_count", got_pats.size(), 1000);
            check("lat3_pat_seq_bad", seq_bad(), 0);
            check("lat3_lat", done_at, 1005);
            check("lat3_done_cnt", done_cnt, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
